// File: rtl/bist_tpg_6b.sv
// BIST test-pattern generator: exhaustive or LFSR 6-bit vectors with golden
// per-group thermometer and total popcount, delivered over valid/ready.
module bist_tpg_6b #(
  parameter logic [5:0] LFSR_SEED = 6'b000001,
  parameter int         PAT_COUNT = 64
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic       mode,
  input  logic       ready_in,
  output logic       pat_valid,
  output logic [5:0] pat,
  output logic [2:0] exp_lo,
  output logic [2:0] exp_hi,
  output logic [2:0] exp_cnt,
  output logic       last,
  output logic       busy,
  output logic       done
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  // A zero seed would lock the LFSR, so it is promoted to 1.
  localparam logic [5:0] SEED     = (LFSR_SEED == 6'd0) ? 6'd1 : LFSR_SEED;
  localparam logic [6:0] LAST_IDX = 7'(PAT_COUNT - 1);

  function automatic logic [1:0] pop3(input logic [2:0] v);
    return {1'b0, v[0]} + {1'b0, v[1]} + {1'b0, v[2]};
  endfunction

  function automatic logic [2:0] therm3(input logic [1:0] n);
    case (n)
      2'd0:    return 3'b000;
      2'd1:    return 3'b001;
      2'd2:    return 3'b011;
      default: return 3'b111;
    endcase
  endfunction

  state_t     r_state;
  logic       r_mode;
  logic [6:0] r_idx;
  logic [5:0] r_lfsr;

  state_t     w_state_nxt;
  logic       w_mode_nxt;
  logic [6:0] w_idx_nxt;
  logic [6:0] w_idx_inc;
  logic [5:0] w_lfsr_nxt;
  logic [5:0] w_lfsr_step;
  logic [5:0] w_pat_nxt;
  logic       w_valid_nxt;
  logic       w_last_nxt;
  logic       w_busy_nxt;
  logic       w_done_nxt;
  logic [1:0] w_pop_lo;
  logic [1:0] w_pop_hi;

  assign w_idx_inc   = r_idx + 7'd1;
  assign w_lfsr_step = {r_lfsr[4:0], r_lfsr[5] ^ r_lfsr[4]};
  assign w_pop_lo    = pop3(w_pat_nxt[2:0]);
  assign w_pop_hi    = pop3(w_pat_nxt[5:3]);

  // Next-state and next-output decode; everything holds unless changed below.
  always_comb begin
    w_state_nxt = r_state;
    w_mode_nxt  = r_mode;
    w_idx_nxt   = r_idx;
    w_lfsr_nxt  = r_lfsr;
    w_pat_nxt   = pat;
    w_valid_nxt = pat_valid;
    w_last_nxt  = last;
    w_busy_nxt  = busy;
    w_done_nxt  = done;
    case (r_state)
      S_IDLE, S_DONE: begin
        if (start) begin
          w_state_nxt = S_RUN;
          w_mode_nxt  = mode;
          w_idx_nxt   = 7'd0;
          w_lfsr_nxt  = SEED;
          w_pat_nxt   = mode ? SEED : 6'd0;
          w_valid_nxt = 1'b1;
          w_last_nxt  = (LAST_IDX == 7'd0);
          w_busy_nxt  = 1'b1;
          w_done_nxt  = 1'b0;
        end else begin
          w_state_nxt = r_state;
        end
      end
      S_RUN: begin
        if (pat_valid && ready_in) begin
          if (last) begin
            w_state_nxt = S_DONE;
            w_valid_nxt = 1'b0;
            w_last_nxt  = 1'b0;
            w_busy_nxt  = 1'b0;
            w_done_nxt  = 1'b1;
          end else begin
            w_idx_nxt  = w_idx_inc;
            w_lfsr_nxt = w_lfsr_step;
            // After 63 LFSR states the all-zero vector closes full coverage.
            if (r_mode) begin
              if (r_idx == 7'd62) begin
                w_pat_nxt = 6'd0;
              end else begin
                w_pat_nxt = w_lfsr_step;
              end
            end else begin
              w_pat_nxt = w_idx_inc[5:0];
            end
            w_last_nxt = (w_idx_inc == LAST_IDX);
          end
        end else begin
          w_state_nxt = S_RUN;
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
        w_idx_nxt   = 7'd0;
        w_lfsr_nxt  = SEED;
        w_pat_nxt   = 6'd0;
        w_valid_nxt = 1'b0;
        w_last_nxt  = 1'b0;
        w_busy_nxt  = 1'b0;
        w_done_nxt  = 1'b0;
      end
    endcase
  end

  // State, sequencing registers and registered outputs with golden values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= S_IDLE;
      r_mode    <= 1'b0;
      r_idx     <= 7'd0;
      r_lfsr    <= SEED;
      pat_valid <= 1'b0;
      pat       <= 6'd0;
      exp_lo    <= 3'd0;
      exp_hi    <= 3'd0;
      exp_cnt   <= 3'd0;
      last      <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_mode    <= w_mode_nxt;
      r_idx     <= w_idx_nxt;
      r_lfsr    <= w_lfsr_nxt;
      pat_valid <= w_valid_nxt;
      pat       <= w_pat_nxt;
      exp_lo    <= therm3(w_pop_lo);
      exp_hi    <= therm3(w_pop_hi);
      exp_cnt   <= {1'b0, w_pop_lo} + {1'b0, w_pop_hi};
      last      <= w_last_nxt;
      busy      <= w_busy_nxt;
      done      <= w_done_nxt;
    end
  end

endmodule

// File: tb/tb_bist_tpg_6b.sv
// Self-checking bench for bist_tpg_6b: three instances (64, 1 and 5 patterns)
// checked against an index-based pattern model with randomized backpressure.
module tb_bist_tpg_6b;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic mode = 1'b0;
  logic ready_in = 1'b0;
  logic start64 = 1'b0, start1 = 1'b0, start5 = 1'b0;

  logic       valid64, last64, busy64, done64;
  logic [5:0] pat64;
  logic [2:0] lo64, hi64, cnt64;
  logic       valid1, last1, busy1, done1;
  logic [5:0] pat1;
  logic [2:0] lo1, hi1, cnt1;
  logic       valid5, last5, busy5, done5;
  logic [5:0] pat5;
  logic [2:0] lo5, hi5, cnt5;

  int checks = 0;
  int failures = 0;

  logic [5:0] lfsr_seq [64];
  logic [5:0] acc_pat [$];
  logic [2:0] acc_lo [$], acc_hi [$], acc_cnt [$];
  logic       acc_last [$];
  int         acc_cyc;
  bit         timed_out;

  always #5 clk = ~clk;

  bist_tpg_6b #(.LFSR_SEED(6'b000001), .PAT_COUNT(64)) u_dut (
    .clk(clk), .rst_n(rst_n), .start(start64), .mode(mode), .ready_in(ready_in),
    .pat_valid(valid64), .pat(pat64), .exp_lo(lo64), .exp_hi(hi64), .exp_cnt(cnt64),
    .last(last64), .busy(busy64), .done(done64));

  bist_tpg_6b #(.LFSR_SEED(6'b000001), .PAT_COUNT(1)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .start(start1), .mode(mode), .ready_in(ready_in),
    .pat_valid(valid1), .pat(pat1), .exp_lo(lo1), .exp_hi(hi1), .exp_cnt(cnt1),
    .last(last1), .busy(busy1), .done(done1));

  bist_tpg_6b #(.LFSR_SEED(6'b000001), .PAT_COUNT(5)) u_dut5 (
    .clk(clk), .rst_n(rst_n), .start(start5), .mode(mode), .ready_in(ready_in),
    .pat_valid(valid5), .pat(pat5), .exp_lo(lo5), .exp_hi(hi5), .exp_cnt(cnt5),
    .last(last5), .busy(busy5), .done(done5));

  function automatic int ones(input logic [5:0] p);
    int n = 0;
    for (int i = 0; i < 6; i++) n += int'(p[i]);
    return n;
  endfunction

  function automatic logic [2:0] therm(input int n);
    logic [3:0] t;
    t = (4'd1 << n) - 4'd1;
    return t[2:0];
  endfunction

  function automatic logic [5:0] ref_pat(input logic m, input int k);
    return m ? lfsr_seq[k] : 6'(k);
  endfunction

  // Record every accepted pattern of the 64-pattern instance until its last one.
  task automatic collect(input bit stall, input int maxcyc);
    acc_pat.delete(); acc_lo.delete(); acc_hi.delete(); acc_cnt.delete(); acc_last.delete();
    timed_out = 1'b0;
    acc_cyc = 0;
    for (int c = 0; c < maxcyc; c++) begin
      ready_in = stall ? 1'($urandom_range(0, 1)) : 1'b1;
      if (valid64 && ready_in) begin
        acc_pat.push_back(pat64); acc_lo.push_back(lo64); acc_hi.push_back(hi64);
        acc_cnt.push_back(cnt64); acc_last.push_back(last64);
        if (last64) begin
          acc_cyc = c + 1;
          ready_in = 1'b1;
          @(negedge clk);
          return;
        end
      end
      @(negedge clk);
    end
    timed_out = 1'b1;
    ready_in = 1'b1;
  endtask

  task automatic do_start(input logic m);
    start64 = 1'b1;
    mode = m;
    @(negedge clk);
    start64 = 1'b0;
  endtask

  task automatic test_reset();
    #3;
    checks++;
    if ({valid64, pat64, lo64, hi64, cnt64, last64, busy64, done64} !== 22'd0) begin
      failures++; $display("FAIL reset_state got=%h exp=0", {valid64, pat64, lo64, hi64, cnt64, last64, busy64, done64});
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    do_start(1'b0);
    ready_in = 1'b1;
    repeat (3) @(negedge clk);
    checks++;
    if (pat64 !== 6'd3 || valid64 !== 1'b1) begin
      failures++; $display("FAIL midrun_pat got=%h exp=03", pat64);
    end
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if ({valid64, pat64, lo64, hi64, cnt64, last64, busy64, done64} !== 22'd0) begin
      failures++; $display("FAIL async_reset got=%h exp=0", {valid64, pat64, lo64, hi64, cnt64, last64, busy64, done64});
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    checks++;
    if (busy64 !== 1'b0 || done64 !== 1'b0) begin
      failures++; $display("FAIL reset_idle busy=%b done=%b exp=0/0", busy64, done64);
    end
    do_start(1'b0);
    checks++;
    if (pat64 !== 6'd0 || valid64 !== 1'b1 || busy64 !== 1'b1) begin
      failures++; $display("FAIL restart_after_reset pat=%h valid=%b busy=%b exp=00/1/1", pat64, valid64, busy64);
    end
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_exhaustive();
    do_start(1'b0);
    collect(1'b0, 200);
    checks++;
    if (timed_out || acc_pat.size() != 64 || acc_cyc != 64) begin
      failures++; $display("FAIL exh_count got=%0d cycles=%0d exp=64/64", acc_pat.size(), acc_cyc);
    end
    for (int k = 0; k < acc_pat.size() && k < 64; k++) begin
      checks++;
      if (acc_pat[k] !== 6'(k) || acc_cnt[k] !== 3'(ones(acc_pat[k]))
          || acc_lo[k] !== therm(ones({3'b000, acc_pat[k][2:0]}))
          || acc_hi[k] !== therm(ones({3'b000, acc_pat[k][5:3]}))
          || acc_last[k] !== (k == 63)) begin
        failures++;
        $display("FAIL exh_pat[%0d] got pat=%h lo=%b hi=%b cnt=%0d last=%b exp pat=%h", k,
                 acc_pat[k], acc_lo[k], acc_hi[k], acc_cnt[k], acc_last[k], 6'(k));
      end
    end
    if (acc_pat.size() == 64) begin
      checks++;
      if (acc_lo[45] !== 3'b011 || acc_hi[45] !== 3'b011 || acc_cnt[45] !== 3'b100) begin
        failures++; $display("FAIL exh_101101 got lo=%b hi=%b cnt=%b exp 011/011/100", acc_lo[45], acc_hi[45], acc_cnt[45]);
      end
      checks++;
      if (acc_lo[63] !== 3'b111 || acc_hi[63] !== 3'b111 || acc_cnt[63] !== 3'b110 || acc_last[63] !== 1'b1) begin
        failures++; $display("FAIL exh_63 got lo=%b hi=%b cnt=%b last=%b", acc_lo[63], acc_hi[63], acc_cnt[63], acc_last[63]);
      end
    end
    checks++;
    if (done64 !== 1'b1 || valid64 !== 1'b0 || busy64 !== 1'b0 || last64 !== 1'b0 || pat64 !== 6'd63) begin
      failures++; $display("FAIL exh_done done=%b valid=%b busy=%b last=%b pat=%h exp 1/0/0/0/3f", done64, valid64, busy64, last64, pat64);
    end
  endtask

  task automatic test_lfsr();
    logic [5:0] first8 [8];
    bit seen [64];
    first8 = '{6'h01, 6'h02, 6'h04, 6'h08, 6'h10, 6'h21, 6'h03, 6'h06};
    do_start(1'b1);
    collect(1'b0, 200);
    checks++;
    if (timed_out || acc_pat.size() != 64) begin
      failures++; $display("FAIL lfsr_count got=%0d exp=64", acc_pat.size());
    end
    for (int k = 0; k < 8 && k < acc_pat.size(); k++) begin
      checks++;
      if (acc_pat[k] !== first8[k]) begin
        failures++; $display("FAIL lfsr_first[%0d] got=%h exp=%h", k, acc_pat[k], first8[k]);
      end
    end
    for (int i = 0; i < 64; i++) seen[i] = 1'b0;
    for (int k = 0; k < acc_pat.size() && k < 64; k++) begin
      checks++;
      if (acc_pat[k] !== ref_pat(1'b1, k) || seen[acc_pat[k]] || (k < 63 && acc_pat[k] == 6'd0)
          || acc_cnt[k] !== 3'(ones(acc_pat[k])) || acc_last[k] !== (k == 63)) begin
        failures++; $display("FAIL lfsr_pat[%0d] got=%h exp=%h cnt=%0d last=%b", k, acc_pat[k], ref_pat(1'b1, k), acc_cnt[k], acc_last[k]);
      end
      seen[acc_pat[k]] = 1'b1;
    end
  endtask

  task automatic test_backpressure();
    logic [5:0] p_pat; logic [2:0] p_lo, p_hi, p_cnt; logic p_last, p_valid;
    bit prev_stall = 1'b0;
    bit fin = 1'b0;
    int n = 0, stalls = 0;
    do_start(1'b1);
    for (int c = 0; c < 2000 && !fin; c++) begin
      if (prev_stall) begin
        stalls++;
        checks++;
        if ({pat64, lo64, hi64, cnt64, last64, valid64} !== {p_pat, p_lo, p_hi, p_cnt, p_last, p_valid}) begin
          failures++; $display("FAIL bp_stable cyc=%0d got pat=%h exp pat=%h", c, pat64, p_pat);
        end
      end
      ready_in = 1'($urandom_range(0, 1));
      if (valid64 && ready_in) begin
        checks++;
        if (pat64 !== ref_pat(1'b1, n) || cnt64 !== 3'(ones(ref_pat(1'b1, n))) || last64 !== (n == 63)) begin
          failures++; $display("FAIL bp_pat[%0d] got=%h exp=%h last=%b", n, pat64, ref_pat(1'b1, n), last64);
        end
        n++;
        if (last64) fin = 1'b1;
      end
      {p_pat, p_lo, p_hi, p_cnt, p_last, p_valid} = {pat64, lo64, hi64, cnt64, last64, valid64};
      prev_stall = valid64 && !ready_in;
      @(negedge clk);
    end
    ready_in = 1'b1;
    checks++;
    if (n != 64 || !fin || stalls == 0) begin
      failures++; $display("FAIL bp_transfers got=%0d stalls=%0d exp=64 with stalls", n, stalls);
    end
    checks++;
    if (done64 !== 1'b1) begin
      failures++; $display("FAIL bp_done got=%b exp=1", done64);
    end
  endtask

  task automatic test_small_counts();
    int n = 0;
    bit fin = 1'b0;
    ready_in = 1'b0;
    start1 = 1'b1; mode = 1'b1;
    @(negedge clk);
    start1 = 1'b0;
    checks++;
    if (pat1 !== 6'd1 || valid1 !== 1'b1 || last1 !== 1'b1 || lo1 !== 3'b001 || hi1 !== 3'b000 || cnt1 !== 3'd1) begin
      failures++; $display("FAIL pc1_pat pat=%h valid=%b last=%b lo=%b cnt=%0d exp 01/1/1/001/1", pat1, valid1, last1, lo1, cnt1);
    end
    ready_in = 1'b1;
    @(negedge clk);
    checks++;
    if (done1 !== 1'b1 || valid1 !== 1'b0 || busy1 !== 1'b0 || pat1 !== 6'd1) begin
      failures++; $display("FAIL pc1_done done=%b valid=%b busy=%b pat=%h exp 1/0/0/01", done1, valid1, busy1, pat1);
    end
    start5 = 1'b1; mode = 1'b0;
    @(negedge clk);
    start5 = 1'b0;
    for (int c = 0; c < 50 && !fin; c++) begin
      if (valid5) begin
        checks++;
        if (pat5 !== 6'(n) || last5 !== (n == 4) || cnt5 !== 3'(ones(6'(n)))) begin
          failures++; $display("FAIL pc5_pat[%0d] got=%h last=%b exp=%h last=%b", n, pat5, last5, 6'(n), (n == 4));
        end
        n++;
        if (last5) fin = 1'b1;
      end
      @(negedge clk);
    end
    checks++;
    if (n != 5 || done5 !== 1'b1) begin
      failures++; $display("FAIL pc5_count got=%0d done=%b exp=5/1", n, done5);
    end
  endtask

  task automatic test_start_control();
    int n = 0;
    bit fin = 1'b0;
    do_start(1'b0);
    for (int c = 0; c < 200 && !fin; c++) begin
      ready_in = 1'b1;
      start64 = (c == 2 || c == 3);
      mode = 1'b1;
      if (valid64) begin
        checks++;
        if (pat64 !== 6'(n)) begin
          failures++; $display("FAIL busy_start_pat[%0d] got=%h exp=%h", n, pat64, 6'(n));
        end
        n++;
        if (last64) begin
          fin = 1'b1;
          start64 = 1'b1;
        end
      end
      @(negedge clk);
    end
    checks++;
    if (n != 64 || done64 !== 1'b1 || busy64 !== 1'b0 || valid64 !== 1'b0) begin
      failures++; $display("FAIL held_start_done n=%0d done=%b busy=%b exp 64/1/0", n, done64, busy64);
    end
    @(negedge clk);
    start64 = 1'b0;
    checks++;
    if (done64 !== 1'b0 || busy64 !== 1'b1 || valid64 !== 1'b1 || pat64 !== 6'h01) begin
      failures++; $display("FAIL held_start_restart done=%b busy=%b pat=%h exp 0/1/01", done64, busy64, pat64);
    end
  endtask

  initial begin
    logic [5:0] s;
    s = 6'b000001;
    for (int k = 0; k < 63; k++) begin
      lfsr_seq[k] = s;
      s = {s[4:0], s[5] ^ s[4]};
    end
    lfsr_seq[63] = 6'd0;
    test_reset();
    test_exhaustive();
    test_lfsr();
    test_backpressure();
    test_small_counts();
    test_start_control();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

endmodule
